ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8, number of consecutive equal ps2c samples required to change the filtered clock level.
REQ-002 Parameter TIMEOUT_CYCLES, default 8191, maximum clk_i cycles allowed between consecutive filtered falling edges inside a frame.
REQ-003 clk_i  input  1  system clock; the only clock in the block.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 rx_en_i  input  1  receive enable; low forces the FSM to IDLE (the host transmitter owns the bus).
REQ-006 ps2c_i  input  1  PS/2 clock line, asynchronous, idle high.
REQ-007 ps2d_i  input  1  PS/2 data line, asynchronous, idle high.
REQ-008 data_o  output  8  last byte received with good parity and stop bit.
REQ-009 valid_o  output  1  one-cycle pulse when data_o is updated.
REQ-010 parity_err_o  output  1  one-cycle pulse when a frame fails odd parity.
REQ-011 frame_err_o  output  1  one-cycle pulse on bad stop bit or inter-edge timeout.
REQ-012 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 ps2c_i and ps2d_i SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 The synchronized ps2c SHALL shift into a FILTER_LEN-bit register every cycle; the filtered clock SHALL go to 1 when all bits are 1, go to 0 when all bits are 0, and otherwise hold.
REQ-015 A registered strobe fall SHALL be high for exactly one cycle after each 1->0 transition of the filtered clock; a ps2c pulse shorter than FILTER_LEN cycles SHALL NOT produce fall.
REQ-016 The FSM SHALL have states IDLE, DATA, PARITY, STOP and SHALL sample synchronized ps2d only in cycles where fall is high.
REQ-017 IDLE: on fall with sampled data 0 (start bit) and rx_en_i high -> DATA with bit counter 0; on fall with sampled data 1 -> remain in IDLE with no output pulse.
REQ-018 DATA: each fall shifts the sampled bit into the shift register LSB-first and increments the counter; after the 8th bit -> PARITY.
REQ-019 PARITY: on fall, store the parity bit -> STOP.
REQ-020 STOP: on fall -> IDLE; if stop bit is 1 and XOR(8 data bits, parity bit) is 1, data_o SHALL load the byte and valid_o SHALL pulse in the next cycle; if stop bit is 1 and parity fails, parity_err_o SHALL pulse in the next cycle; if stop bit is 0, frame_err_o SHALL pulse in the next cycle regardless of parity.
REQ-021 Exactly one of valid_o, parity_err_o, frame_err_o SHALL pulse per completed frame; data_o SHALL change only together with valid_o.
REQ-022 A timeout counter SHALL reload on every fall and decrement each cycle while busy_o is high; reaching 0 outside IDLE SHALL force IDLE and pulse frame_err_o once in the next cycle.
REQ-023 rx_en_i low in any state SHALL force IDLE within one cycle, discard the partial frame, and produce no output pulse; the filter SHALL keep running.
REQ-024 fall and timeout expiry in the same cycle: fall SHALL take priority.

Reset
REQ-025 reset_ni low SHALL immediately set state IDLE, data_o 0x00, valid_o, parity_err_o, frame_err_o and busy_o 0, synchronizer and filter registers all ones, filtered clock 1, counters 0.
REQ-026 Reset asserted mid-frame SHALL discard the frame; after release the next start bit SHALL be received normally.

Verification
REQ-027 Frame 0, bits 0x1C LSB-first, parity 0, stop 1 -> valid_o one pulse, data_o = 0x1C, no error pulses.
REQ-028 Same frame with parity 1 -> parity_err_o one pulse, valid_o 0, data_o unchanged.
REQ-029 Frame 0xAA, parity 1, stop bit 0 -> frame_err_o one pulse, valid_o 0.
REQ-030 Clock stopped high after 4 data bits -> frame_err_o pulses TIMEOUT_CYCLES (+/-2) cycles after the last fall, busy_o returns 0; a following 0x55 frame is received correctly.
REQ-031 ps2c glitch low for FILTER_LEN-2 cycles while idle -> busy_o stays 0, no pulses.
REQ-032 reset_ni pulsed low after bit 3, or rx_en_i dropped mid-frame -> no pulses, busy_o 0, next 0xF0 frame yields valid_o with data_o = 0xF0.

Source files
------------

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
// Synchronizes and deglitches the PS/2 clock, samples data on filtered falling
// edges, and reports each 11-bit frame as a good byte, a parity error or a
// framing error (bad stop bit or stalled clock).
module ps2_rx #(
  parameter int unsigned FILTER_LEN     = 8,    // must be at least 2
  parameter int unsigned TIMEOUT_CYCLES = 8191
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       rx_en_i,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [1:0]            ps2c_sync_q;
  logic [1:0]            ps2d_sync_q;
  logic                  ps2c_s;
  logic                  ps2d_s;
  logic [FILTER_LEN-1:0] filter_q;
  logic                  clk_filt_q;
  logic                  clk_filt_d;
  logic                  fall_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            shift_q;
  logic                  parity_q;
  logic [TO_W-1:0]       timeout_q;
  logic                  timeout_hit;
  logic                  frame_done;
  logic                  frame_good;
  logic                  frame_par_bad;
  logic                  frame_stop_bad;
  logic                  timeout_err;

  assign ps2c_s = ps2c_sync_q[1];
  assign ps2d_s = ps2d_sync_q[1];

  // Two-flop synchronizers for both asynchronous PS/2 lines; idle level is high.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[0], ps2c_i};
      ps2d_sync_q <= {ps2d_sync_q[0], ps2d_i};
    end
  end

  // The filtered clock only moves once the whole sample window agrees.
  always_comb begin
    clk_filt_d = clk_filt_q;
    if (&filter_q) begin
      clk_filt_d = 1'b1;
    end else if (~|filter_q) begin
      clk_filt_d = 1'b0;
    end
  end

  // Sample window, filtered level and the one-cycle falling-edge strobe.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      filter_q   <= {FILTER_LEN{1'b1}};
      clk_filt_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      filter_q   <= {filter_q[FILTER_LEN-2:0], ps2c_s};
      clk_filt_q <= clk_filt_d;
      fall_q     <= clk_filt_q & ~clk_filt_d;
    end
  end

  // Inter-edge watchdog: reloaded on every edge, counts down while a frame is open.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      timeout_q <= '0;
    end else if (fall_q) begin
      timeout_q <= TO_W'(TIMEOUT_CYCLES);
    end else if (busy_o && (timeout_q != '0)) begin
      timeout_q <= timeout_q - TO_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: disable beats an edge, and an edge beats the watchdog.
  always_comb begin
    state_d = state_q;
    if (!rx_en_i) begin
      state_d = IDLE;
    end else if (fall_q) begin
      case (state_q)
        IDLE:    if (!ps2d_s) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  // FSM outputs: busy flag and end-of-frame outcome decode.
  always_comb begin
    busy_o         = (state_q != IDLE);
    timeout_hit    = (state_q != IDLE) && (timeout_q == '0);
    frame_done     = rx_en_i && fall_q && (state_q == STOP);
    frame_good     = frame_done && ps2d_s && (^{shift_q, parity_q});
    frame_par_bad  = frame_done && ps2d_s && !(^{shift_q, parity_q});
    frame_stop_bad = frame_done && !ps2d_s;
    timeout_err    = rx_en_i && !fall_q && timeout_hit;
  end

  // Frame datapath: bit capture on edges and registered result pulses.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      valid_o      <= frame_good;
      parity_err_o <= frame_par_bad;
      frame_err_o  <= frame_stop_bad | timeout_err;
      if (frame_good) begin
        data_o <= shift_q;
      end
      if (rx_en_i && fall_q) begin
        case (state_q)
          IDLE: bit_cnt_q <= '0;
          DATA: begin
            shift_q   <= {ps2d_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          PARITY:  parity_q <= ps2d_s;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed and randomized PS/2 frames against a frame-level model.
module tb_ps2_rx;

  localparam int FILT   = 8;
  localparam int TMO    = 300;
  localparam int HALF   = 20;
  localparam int SETTLE = 30;

  logic       clk;
  logic       reset_ni;
  logic       rx_en_i;
  logic       ps2c_i;
  logic       ps2d_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int valid_cnt = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ferr_cycle = 0;
  int last_fall_cycle = 0;
  int data_glitch = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_data = 8'h00;

  ps2_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk),
    .reset_ni(reset_ni),
    .rx_en_i(rx_en_i),
    .ps2c_i(ps2c_i),
    .ps2d_i(ps2d_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .parity_err_o(parity_err_o),
    .frame_err_o(frame_err_o),
    .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  // Pulse counters and a watch on data_o moving without valid_o.
  always @(negedge clk) begin
    if (valid_o) valid_cnt++;
    if (parity_err_o) perr_cnt++;
    if (frame_err_o) begin
      ferr_cnt++;
      ferr_cycle = cycle;
    end
    if (reset_ni && !valid_o && (data_o !== prev_data)) data_glitch++;
    prev_data = data_o;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  // Drive the first nbits bits of a frame, LSB first, as a PS/2 device would.
  task automatic apply_stimulus(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2d_i = frame[i];
      wait_cycles(HALF);
      ps2c_i = 1'b0;
      last_fall_cycle = cycle;
      wait_cycles(HALF);
      ps2c_i = 1'b1;
    end
    ps2d_i = 1'b1;
  endtask

  task automatic clear_counts();
    valid_cnt = 0;
    perr_cnt  = 0;
    ferr_cnt  = 0;
  endtask

  task automatic check_frame(input string tag, input int ev, input int ep, input int ef);
    check_output({tag, "_valid"}, valid_cnt, ev);
    check_output({tag, "_perr"}, perr_cnt, ep);
    check_output({tag, "_ferr"}, ferr_cnt, ef);
    check_output({tag, "_data"}, int'(data_o), int'(exp_data));
    check_output({tag, "_busy"}, int'(busy_o), 0);
    clear_counts();
  endtask

  // Frame-level reference: the stop bit decides framing, then odd parity decides the rest.
  task automatic run_frame(input string tag, input logic [10:0] frame);
    logic [7:0] d;
    int ev, ep, ef;
    d  = frame[8:1];
    ev = 0;
    ep = 0;
    ef = 0;
    if (frame[10] == 1'b0) ef = 1;
    else if ((^d ^ frame[9]) == 1'b1) begin
      ev = 1;
      exp_data = d;
    end else ep = 1;
    clear_counts();
    apply_stimulus(frame, 11);
    wait_cycles(SETTLE);
    check_frame(tag, ev, ep, ef);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rpar;
    logic       rstop;
    int         kind;
    int         diff;
    int         to_exp;

    reset_ni = 1'b0;
    rx_en_i  = 1'b1;
    ps2c_i   = 1'b1;
    ps2d_i   = 1'b1;
    wait_cycles(5);
    check_output("reset_data", int'(data_o), 0);
    check_output("reset_valid", int'(valid_o), 0);
    check_output("reset_perr", int'(parity_err_o), 0);
    check_output("reset_ferr", int'(frame_err_o), 0);
    check_output("reset_busy", int'(busy_o), 0);
    reset_ni = 1'b1;
    wait_cycles(20);
    clear_counts();

    $display("[TB] directed frames");
    run_frame("good_1c", make_frame(8'h1C, 1'b0, 1'b1));
    run_frame("par_1c", make_frame(8'h1C, 1'b1, 1'b1));
    run_frame("stop_aa", make_frame(8'hAA, 1'b1, 1'b0));

    $display("[TB] stalled clock");
    clear_counts();
    apply_stimulus(make_frame(8'h3C, 1'b1, 1'b1), 5);
    wait_cycles(2);
    check_output("stall_busy_mid", int'(busy_o), 1);
    for (int k = 0; (k < TMO + 200) && (ferr_cnt == 0); k++) wait_cycles(1);
    diff   = ferr_cycle - last_fall_cycle;
    to_exp = FILT + 4 + TMO;
    check_output($sformatf("stall_latency_%0d", diff),
                 int'((diff >= to_exp - 3) && (diff <= to_exp + 3)), 1);
    wait_cycles(SETTLE);
    check_frame("stall", 0, 0, 1);
    run_frame("after_stall_55", make_frame(8'h55, 1'b1, 1'b1));

    $display("[TB] clock glitch");
    clear_counts();
    ps2c_i = 1'b0;
    wait_cycles(FILT - 2);
    ps2c_i = 1'b1;
    wait_cycles(4);
    check_output("glitch_busy_mid", int'(busy_o), 0);
    wait_cycles(SETTLE);
    check_frame("glitch", 0, 0, 0);

    $display("[TB] reset mid-frame");
    clear_counts();
    apply_stimulus(make_frame(8'h77, 1'b1, 1'b1), 4);
    check_output("rst_busy_mid", int'(busy_o), 1);
    reset_ni = 1'b0;
    exp_data = 8'h00;
    wait_cycles(3);
    check_output("rst_busy_low", int'(busy_o), 0);
    reset_ni = 1'b1;
    wait_cycles(SETTLE);
    check_frame("rst_abort", 0, 0, 0);
    run_frame("after_rst_f0", make_frame(8'hF0, 1'b1, 1'b1));

    $display("[TB] enable dropped mid-frame");
    clear_counts();
    apply_stimulus(make_frame(8'h0F, 1'b1, 1'b1), 6);
    check_output("en_busy_mid", int'(busy_o), 1);
    rx_en_i = 1'b0;
    wait_cycles(2);
    check_output("en_busy_low", int'(busy_o), 0);
    wait_cycles(SETTLE);
    check_frame("en_abort", 0, 0, 0);
    rx_en_i = 1'b1;
    wait_cycles(10);
    run_frame("after_en_f0", make_frame(8'hF0, 1'b1, 1'b1));

    $display("[TB] random frames");
    for (int n = 0; n < 10; n++) begin
      rd   = 8'($urandom);
      kind = int'($urandom_range(0, 2));
      rpar = ~^rd;
      rstop = 1'b1;
      if (kind == 1) rpar = ^rd;
      if (kind == 2) begin
        rpar  = 1'($urandom);
        rstop = 1'b0;
      end
      run_frame($sformatf("rand%0d", n), make_frame(rd, rpar, rstop));
    end

    check_output("data_change_without_valid", data_glitch, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
